// File: rtl/local_pattern_predictor_if.sv
// Lookup/prediction/resolve bundle between the local history table, the
// local pattern predictor and the tournament chooser.
interface local_pattern_predictor_if #(
  parameter int unsigned HIST_W = 10,
  parameter int unsigned CTR_W  = 3
);
  logic              hist_valid;
  logic [HIST_W-1:0] hist;
  logic              hist_ready;
  logic              pred_valid;
  logic              pred_taken;
  logic [CTR_W-1:0]  pred_ctr;
  logic              resolve_valid;
  logic              resolve_taken;

  modport master (
    output hist_valid, hist, resolve_valid, resolve_taken,
    input  hist_ready, pred_valid, pred_taken, pred_ctr
  );

  modport slave (
    input  hist_valid, hist, resolve_valid, resolve_taken,
    output hist_ready, pred_valid, pred_taken, pred_ctr
  );
endinterface

// File: rtl/local_pattern_predictor.sv
// Local pattern predictor: history-indexed saturating counters with an ordered
// in-flight queue for retraining. Define LPP_FLUSH_EN to add the flush port.
module local_pattern_predictor #(
  parameter int unsigned HIST_W  = 10,
  parameter int unsigned CTR_W   = 3,
  parameter int unsigned Q_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  local_pattern_predictor_if.slave  bus,
`ifdef LPP_FLUSH_EN
  input  logic                      flush,
`endif
  output logic                      init_done,
  output logic                      resolve_err
);

  localparam int unsigned PW  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(Q_DEPTH + 1);
  localparam int unsigned TBL = 1 << HIST_W;

  localparam logic [CTR_W-1:0] WNT      = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CW-1:0]    QFULL    = CW'(Q_DEPTH);
  localparam logic [PW-1:0]    PTR_LAST = PW'(Q_DEPTH - 1);

  typedef enum logic [1:0] {S_INIT, S_LAST, S_RUN} state_t;

  state_t            state;
  logic [CTR_W-1:0]  table_q [TBL];
  logic [HIST_W-1:0] queue_q [Q_DEPTH];
  logic [HIST_W-1:0] init_ptr;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_nxt;

  logic              flush_req;
  logic              run, accept, pop, err_set;
  logic [HIST_W-1:0] head_idx;
  logic [CTR_W-1:0]  head_ctr, upd_ctr, look_ctr;
  logic              mem_we;
  logic [HIST_W-1:0] mem_wa;
  logic [CTR_W-1:0]  mem_wd;

`ifdef LPP_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    run      = (state == S_RUN);
    accept   = run && bus.hist_valid && bus.hist_ready && !flush_req;
    pop      = run && bus.resolve_valid && (count != '0) && !flush_req;
    err_set  = run && bus.resolve_valid && (count == '0) && !flush_req;
    head_idx = queue_q[rd_ptr];
    head_ctr = table_q[head_idx];
    if (bus.resolve_taken)
      upd_ctr = (head_ctr == CTR_MAX) ? head_ctr : head_ctr + CTR_W'(1);
    else
      upd_ctr = (head_ctr == '0) ? head_ctr : head_ctr - CTR_W'(1);
    // A lookup hitting the entry being retrained this cycle sees the new value
    look_ctr = (pop && (head_idx == bus.hist)) ? upd_ctr : table_q[bus.hist];

    count_nxt = count;
    if (flush_req)
      count_nxt = '0;
    else if (accept && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !accept)
      count_nxt = count - CW'(1);

    mem_we = 1'b0;
    mem_wa = head_idx;
    mem_wd = upd_ctr;
    if (state == S_INIT) begin
      mem_we = 1'b1;
      mem_wa = init_ptr;
      mem_wd = WNT;
    end else if (pop) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_INIT;
      init_ptr       <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_ctr   <= '0;
      bus.hist_ready <= 1'b0;
      init_done      <= 1'b0;
      resolve_err    <= 1'b0;
    end else begin
      bus.pred_valid <= accept;
      if (accept) begin
        bus.pred_taken <= look_ctr[CTR_W-1];
        bus.pred_ctr   <= look_ctr;
      end
      if (err_set)
        resolve_err <= 1'b1;
      count <= count_nxt;
      if (flush_req) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (accept) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      end
      // hist_ready is registered from next-cycle state and occupancy
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + HIST_W'(1);
          if (init_ptr == '1)
            state <= S_LAST;
        end
        S_LAST: begin
          state          <= S_RUN;
          init_done      <= 1'b1;
          bus.hist_ready <= 1'b1;
        end
        S_RUN: begin
          bus.hist_ready <= (count_nxt != QFULL);
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (accept)
      queue_q[wr_ptr] <= bus.hist;
    if (mem_we)
      table_q[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_local_pattern_predictor.sv
// Self-checking bench for local_pattern_predictor: cycle model with a queue and
// an integer counter table, plus directed literal checks and random traffic.
module tb_local_pattern_predictor;
  localparam int unsigned HIST_W  = 10;
  localparam int unsigned CTR_W   = 3;
  localparam int unsigned Q_DEPTH = 4;
  localparam int TBL      = 1 << HIST_W;
  localparam int INIT_CYC = TBL + 1;
  localparam int CMAX     = (1 << CTR_W) - 1;
  localparam int WNT_I    = (1 << (CTR_W - 1)) - 1;
  localparam int HALF     = 1 << (CTR_W - 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic init_done, resolve_err;

  int tests  = 0;
  int failed = 0;

  local_pattern_predictor_if #(.HIST_W(HIST_W), .CTR_W(CTR_W)) bus ();

  local_pattern_predictor #(.HIST_W(HIST_W), .CTR_W(CTR_W), .Q_DEPTH(Q_DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
`ifdef LPP_FLUSH_EN
    .flush       (flush),
`endif
    .init_done   (init_done),
    .resolve_err (resolve_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int tbl [TBL];
  int q [$];
  int m_cycles = 0;
  int m_pc = 0;
  bit m_pv = 0, m_pt = 0, m_done = 0, m_err = 0, m_ready = 0;
  bit checking = 0;

  always @(posedge clock) begin
    bit fl, acc, res;
    int idx;
    if (reset) begin
      checking = 1;
      m_cycles = 0;
      q.delete();
      m_pv = 0; m_pt = 0; m_pc = 0; m_err = 0; m_ready = 0; m_done = 0;
      foreach (tbl[i]) tbl[i] = WNT_I;
    end else begin
`ifdef LPP_FLUSH_EN
      fl = flush;
`else
      fl = 0;
`endif
      acc = m_done && m_ready && bus.hist_valid && !fl;
      res = m_done && bus.resolve_valid && !fl;
      if (res) begin
        if (q.size() == 0) m_err = 1;
        else begin
          idx = q.pop_front();
          if (bus.resolve_taken) tbl[idx] = (tbl[idx] < CMAX) ? tbl[idx] + 1 : CMAX;
          else                   tbl[idx] = (tbl[idx] > 0)    ? tbl[idx] - 1 : 0;
        end
      end
      m_pv = acc;
      if (acc) begin
        m_pc = tbl[int'(bus.hist)];
        m_pt = (m_pc >= HALF);
        q.push_back(int'(bus.hist));
      end
      if (fl) q.delete();
      m_cycles++;
      if (m_cycles >= INIT_CYC) m_done = 1;
      m_ready = m_done && (q.size() < int'(Q_DEPTH));
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("hist_ready",  bus.hist_ready, m_ready);
      chk("init_done",   init_done,      m_done);
      chk("resolve_err", resolve_err,    m_err);
      chk("pred_valid",  bus.pred_valid, m_pv);
      chk("pred_taken",  bus.pred_taken, m_pt);
      chk("pred_ctr",    bus.pred_ctr,   m_pc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_in();
    bus.hist_valid = 0; bus.hist = '0; bus.resolve_valid = 0; bus.resolve_taken = 0; flush = 0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 2000) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic lookup(input logic [HIST_W-1:0] h);
    bus.hist_valid = 1; bus.hist = h;
    @(negedge clock);
    bus.hist_valid = 0;
  endtask

  task automatic resolve(input logic t);
    bus.resolve_valid = 1; bus.resolve_taken = t;
    @(negedge clock);
    bus.resolve_valid = 0;
  endtask

  task automatic lookup_chk(input string name, input logic [HIST_W-1:0] h, input int exp);
    lookup(h);
    chk({name, "_valid"}, bus.pred_valid, 1);
    chk({name, "_ctr"},   bus.pred_ctr,   exp);
    chk({name, "_taken"}, bus.pred_taken, (exp >= HALF) ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int up_exp [5]  = '{4, 5, 6, 7, 7};
    int dn_exp [8]  = '{6, 5, 4, 3, 2, 1, 0, 0};
    clear_in();
    @(negedge clock);

    // Init latency and default counter value
    do_reset();
    wait_init(n);
    chk("init_latency", n, 1025);
    lookup_chk("init_val", 10'h3FF, 3);
    resolve(0);

    // Saturating training on 0x155
    lookup_chk("t0", 10'h155, 3);
    for (int i = 0; i < 5; i++) begin
      resolve(1);
      lookup_chk("up", 10'h155, up_exp[i]);
    end
    for (int i = 0; i < 8; i++) begin
      resolve(0);
      lookup_chk("dn", 10'h155, dn_exp[i]);
    end
    resolve(0);

    // Queue full, back-pressure and same-cycle accept+resolve
    do_reset();
    wait_init(n);
    for (int i = 0; i < 4; i++) lookup(10'h10 + 10'(i));
    chk("full_ready", bus.hist_ready, 0);
    lookup(10'h20);
    chk("full_reject", bus.pred_valid, 0);
    bus.resolve_valid = 1; bus.resolve_taken = 1; bus.hist_valid = 1; bus.hist = 10'h20;
    @(negedge clock);
    clear_in();
    chk("full_both_valid", bus.pred_valid, 0);
    chk("full_both_ready", bus.hist_ready, 1);
    bus.resolve_valid = 1; bus.resolve_taken = 1; bus.hist_valid = 1; bus.hist = 10'h10;
    @(negedge clock);
    clear_in();
    chk("both_ctr", bus.pred_ctr, 4);
    chk("both_ready", bus.hist_ready, 1);
    lookup(10'h30);
    chk("refill_full", bus.hist_ready, 0);
    resolve(1); resolve(0); resolve(1); resolve(0);
    lookup_chk("order_13", 10'h13, 2);
    lookup_chk("order_10", 10'h10, 5);
    lookup_chk("order_11", 10'h11, 4);

    // Reset mid-init, then empty-queue resolve error
    do_reset();
    repeat (300) @(negedge clock);
    do_reset();
    wait_init(n);
    chk("reinit_latency", n, 1025);
    resolve(1);
    chk("err_set", resolve_err, 1);
    lookup_chk("err_nochg", 10'h000, 3);
    resolve(1);
    repeat (5) @(negedge clock);
    chk("err_sticky", resolve_err, 1);

    // Write-first forwarding on the same index
    lookup_chk("fwd0", 10'h2A, 3);
    bus.resolve_valid = 1; bus.resolve_taken = 1; bus.hist_valid = 1; bus.hist = 10'h2A;
    @(negedge clock);
    clear_in();
    chk("fwd_ctr", bus.pred_ctr, 4);
    chk("fwd_taken", bus.pred_taken, 1);
    resolve(0);

`ifdef LPP_FLUSH_EN
    do_reset();
    wait_init(n);
    lookup(10'h40); lookup(10'h41); lookup(10'h42);
    flush = 1; bus.resolve_valid = 1; bus.resolve_taken = 1; bus.hist_valid = 1; bus.hist = 10'h43;
    @(negedge clock);
    clear_in();
    chk("flush_pv", bus.pred_valid, 0);
    chk("flush_err", resolve_err, 0);
    chk("flush_ready", bus.hist_ready, 1);
    lookup_chk("flush_nochg", 10'h40, 3);
    resolve(1);
    resolve(1);
    chk("flush_empty", resolve_err, 1);
`endif

    // Random traffic with one mid-run reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset = (c == 2200);
      bus.hist_valid    = 1'($urandom_range(0, 1));
      bus.hist          = ($urandom_range(0, 7) == 0) ? 10'h2A : 10'($urandom_range(0, 7));
      bus.resolve_valid = 1'($urandom_range(0, 1));
      bus.resolve_taken = 1'($urandom_range(0, 1));
`ifdef LPP_FLUSH_EN
      flush = ($urandom_range(0, 15) == 0);
`endif
      @(negedge clock);
    end
    reset = 0;
    clear_in();
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
